// File: rtl/scr1_ytydla_dmem_wide_resp.sv
// YTYDLA wide-LSU DMEM responder: splits a 1..5 word request into sequential
// accesses on a 32-bit single-port synchronous SRAM and returns one response.
package scr1_ytydla_dmem_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    SCR1_MEM_Y_WIDTH_ONE_WORD   = 3'd1,
    SCR1_MEM_Y_WIDTH_TWO_WORD   = 3'd2,
    SCR1_MEM_Y_WIDTH_THREE_WORD = 3'd3,
    SCR1_MEM_Y_WIDTH_FOUR_WORD  = 3'd4,
    SCR1_MEM_Y_WIDTH_FIVE_WORD  = 3'd5
  } type_scr1_mem_y_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

module scr1_ytydla_dmem_wide_resp
  import scr1_ytydla_dmem_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MAX_WORDS = 5,
  parameter int unsigned SRAM_AW   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_y_width_e        dmem_width,
  input  logic [31:0]                   dmem_addr,
  input  logic [WORD_W*MAX_WORDS-1:0]   dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [WORD_W*MAX_WORDS-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic                          sram_ce,
  output logic                          sram_we,
  output logic [SRAM_AW-1:0]            sram_addr,
  output logic [WORD_W-1:0]             sram_wdata,
  input  logic [WORD_W-1:0]             sram_rdata
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam logic [SRAM_AW:0] DEPTH = (SRAM_AW + 1)'(1) << SRAM_AW;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RDLAST,
    RESP,
    RESP_ER
  } state_e;

  state_e                               state;
  state_e                               state_next;

  type_scr1_mem_cmd_e                   cmd_q;
  logic [CW-1:0]                        n_q;
  logic [SRAM_AW-1:0]                   wa_q;
  logic [CW-1:0]                        cnt;
  logic [MAX_WORDS-1:0][WORD_W-1:0]     wbuf;
  logic [MAX_WORDS-1:0][WORD_W-1:0]     rbuf;
  logic                                 rd_pend;
  logic [CW-1:0]                        cap_idx;

  logic [2:0]                           width_code;
  logic [CW-1:0]                        n_in;
  logic [SRAM_AW-1:0]                   wa_in;
  logic [SRAM_AW:0]                     end_in;
  logic                                 width_bad;
  logic                                 align_bad;
  logic                                 win_bad;
  logic                                 range_bad;
  logic                                 req_err;
  logic                                 accept;
  logic                                 last;

  // Request decode and error classification, evaluated in the accept cycle
  assign width_code = dmem_width;
  assign n_in       = CW'(width_code);
  assign wa_in      = dmem_addr[SRAM_AW+1:2];
  assign end_in     = {1'b0, wa_in} + (SRAM_AW + 1)'(n_in);
  assign width_bad  = (width_code == 3'd0) || (32'(width_code) > 32'(MAX_WORDS));
  assign align_bad  = |dmem_addr[1:0];
  assign win_bad    = dmem_addr[31:SRAM_AW+2] != BASE_ADDR[31:SRAM_AW+2];
  assign range_bad  = end_in > DEPTH;
  assign req_err    = width_bad | align_bad | win_bad | range_bad;

  assign accept     = dmem_req && (state == IDLE);
  assign last       = (cnt == n_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    dmem_req_ack = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata   = '0;
    sram_ce      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_wdata   = '0;
    case (state)
      IDLE: begin
        dmem_req_ack = 1'b1;
        if (dmem_req) begin
          state_next = req_err ? RESP_ER : ACCESS;
        end
      end
      ACCESS: begin
        sram_ce    = 1'b1;
        sram_we    = (cmd_q == SCR1_MEM_CMD_WR);
        sram_addr  = wa_q + SRAM_AW'(cnt);
        sram_wdata = wbuf[cnt];
        if (last) begin
          state_next = (cmd_q == SCR1_MEM_CMD_WR) ? RESP : RDLAST;
        end
      end
      RDLAST: begin
        state_next = RESP;
      end
      RESP: begin
        dmem_resp  = SCR1_MEM_RESP_RDY_OK;
        dmem_rdata = rbuf;
        state_next = IDLE;
      end
      RESP_ER: begin
        dmem_resp  = SCR1_MEM_RESP_RDY_ER;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read data lags its issue by one cycle; rd_pend/cap_idx remember which word
  // slot the returning SRAM word belongs to, so issue k+1 overlaps capture k.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= SCR1_MEM_CMD_RD;
      n_q     <= '0;
      wa_q    <= '0;
      cnt     <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
      rd_pend <= 1'b0;
      cap_idx <= '0;
    end else begin
      rd_pend <= (state == ACCESS) && (cmd_q == SCR1_MEM_CMD_RD);
      cap_idx <= cnt;
      if (rd_pend) begin
        rbuf[cap_idx] <= sram_rdata;
      end
      if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        cmd_q <= dmem_cmd;
        n_q   <= n_in;
        wa_q  <= wa_in;
        wbuf  <= dmem_wdata;
        rbuf  <= '0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scr1_ytydla_dmem_wide_resp.sv
// Directed bench for scr1_ytydla_dmem_wide_resp: vector table plus hand-written
// back-to-back and mid-transaction reset sequences against a behavioural SRAM.
module tb_scr1_ytydla_dmem_wide_resp;
  import scr1_ytydla_dmem_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic                   clk;
  logic                   rst;
  logic                   dmem_req;
  type_scr1_mem_cmd_e     dmem_cmd;
  type_scr1_mem_y_width_e dmem_width;
  logic [31:0]            dmem_addr;
  logic [159:0]           dmem_wdata;
  logic                   dmem_req_ack;
  logic [159:0]           dmem_rdata;
  type_scr1_mem_resp_e    dmem_resp;
  logic                   sram_ce;
  logic                   sram_we;
  logic [11:0]            sram_addr;
  logic [31:0]            sram_wdata;
  logic [31:0]            sram_rdata;

  scr1_ytydla_dmem_wide_resp #(
    .WORD_W    (32),
    .MAX_WORDS (5),
    .SRAM_AW   (12),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .sram_ce      (sram_ce),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM; preload pattern is applied while init is high
  logic [31:0] mem [4096];
  logic        init;
  int          ce_cnt;

  function automatic logic [31:0] init_val(input int unsigned i);
    if (i >= 32'h10 && i <= 32'h14) return 32'hA0A0_0000 + (i - 32'h10);
    return 32'h5A00_0000 | i;
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int unsigned i = 0; i < 4096; i++) mem[i] <= init_val(i);
      ce_cnt <= 0;
    end else if (sram_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  int checks;
  int fails;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    type_scr1_mem_cmd_e     cmd;
    type_scr1_mem_y_width_e width;
    logic [31:0]            addr;
    logic [159:0]           wdata;
    type_scr1_mem_resp_e    resp;
    int                     lat;
    logic [159:0]           rdata;
    int                     ces;
  } vec_t;

  vec_t vecs [13];

  // Issues one request in cycle 0 and follows it to its response cycle
  task automatic run_txn(input string name, input vec_t v);
    int lat;
    int ce0;
    logic ack0;
    @(negedge clk);
    dmem_cmd   = v.cmd;
    dmem_width = v.width;
    dmem_addr  = v.addr;
    dmem_wdata = v.wdata;
    dmem_req   = 1'b1;
    #1;
    ack0 = dmem_req_ack;
    ce0  = ce_cnt;
    @(posedge clk);
    #1 dmem_req = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (dmem_resp != SCR1_MEM_RESP_NOTRDY || lat > 20) break;
    end
    chk({name, " ack"},     160'(ack0),            160'(1'b1));
    chk({name, " resp"},    160'(dmem_resp),       160'(v.resp));
    chk({name, " latency"}, 160'(lat),             160'(v.lat));
    chk({name, " rdata"},   dmem_rdata,            v.rdata);
    chk({name, " sram_ce"}, 160'(ce_cnt - ce0),    160'(v.ces));
    @(negedge clk);
    chk({name, " idle"}, 160'({dmem_req_ack, dmem_resp, sram_ce, |dmem_rdata}),
        160'({1'b1, SCR1_MEM_RESP_NOTRDY, 1'b0, 1'b0}));
  endtask

  initial begin
    int acks;
    int oks;
    int ce0;
    int lat;
    logic [159:0] rd0;
    logic any_resp;
    type_scr1_mem_y_width_e bad_w0;
    type_scr1_mem_y_width_e bad_w7;

    checks = 0;
    fails  = 0;
    bad_w0 = type_scr1_mem_y_width_e'(3'd0);
    bad_w7 = type_scr1_mem_y_width_e'(3'd7);

    vecs[0]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_FIVE_WORD, BASE + 32'h40, '0,
                 SCR1_MEM_RESP_RDY_OK, 7,
                 {32'hA0A0_0004, 32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}, 5};
    vecs[1]  = '{SCR1_MEM_CMD_WR, SCR1_MEM_Y_WIDTH_TWO_WORD, BASE + 32'h8,
                 {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF},
                 SCR1_MEM_RESP_RDY_OK, 3, '0, 2};
    vecs[2]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_ONE_WORD, BASE + 32'hC, '1,
                 SCR1_MEM_RESP_RDY_OK, 3, {128'h0, 32'h1234_5678}, 1};
    vecs[3]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_THREE_WORD, BASE + 32'h2, '0,
                 SCR1_MEM_RESP_RDY_ER, 1, '0, 0};
    vecs[4]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_ONE_WORD, BASE - 32'h4, '0,
                 SCR1_MEM_RESP_RDY_ER, 1, '0, 0};
    vecs[5]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_THREE_WORD, BASE + 32'h3FFC, '0,
                 SCR1_MEM_RESP_RDY_ER, 1, '0, 0};
    vecs[6]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_ONE_WORD, BASE + 32'h3FFC, '0,
                 SCR1_MEM_RESP_RDY_OK, 3, {128'h0, 32'h5A00_0FFF}, 1};
    vecs[7]  = '{SCR1_MEM_CMD_WR, bad_w0, BASE, '1, SCR1_MEM_RESP_RDY_ER, 1, '0, 0};
    vecs[8]  = '{SCR1_MEM_CMD_WR, bad_w7, BASE, '1, SCR1_MEM_RESP_RDY_ER, 1, '0, 0};
    vecs[9]  = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_FOUR_WORD, BASE, '0,
                 SCR1_MEM_RESP_RDY_OK, 6,
                 {32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h5A00_0001, 32'h5A00_0000}, 4};
    vecs[10] = '{SCR1_MEM_CMD_WR, SCR1_MEM_Y_WIDTH_FIVE_WORD, BASE + 32'h100,
                 {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                 SCR1_MEM_RESP_RDY_OK, 6, '0, 5};
    vecs[11] = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_FIVE_WORD, BASE + 32'h100, '0,
                 SCR1_MEM_RESP_RDY_OK, 7,
                 {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 5};
    vecs[12] = '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_ONE_WORD, 32'h0002_0000, '0,
                 SCR1_MEM_RESP_RDY_ER, 1, '0, 0};

    rst        = 1'b1;
    init       = 1'b1;
    dmem_req   = 1'b0;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_Y_WIDTH_ONE_WORD;
    dmem_addr  = '0;
    dmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    init = 1'b0;
    @(negedge clk);
    chk("reset outputs", 160'({dmem_req_ack, dmem_resp, sram_ce, sram_we, |dmem_rdata}),
        160'({1'b1, SCR1_MEM_RESP_NOTRDY, 1'b0, 1'b0, 1'b0}));

    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
      if (i == 1) begin
        chk("wr mem[2]", 160'(mem[2]), 160'(32'hDEAD_BEEF));
        chk("wr mem[3]", 160'(mem[3]), 160'(32'h1234_5678));
        chk("wr mem[4] untouched", 160'(mem[4]), 160'(32'h5A00_0004));
      end
    end

    // Back-to-back: request held high across two ONE_WORD reads
    @(negedge clk);
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_Y_WIDTH_ONE_WORD;
    dmem_addr  = BASE + 32'h40;
    dmem_req   = 1'b1;
    acks = 0;
    oks  = 0;
    rd0  = '0;
    ce0  = ce_cnt;
    for (int c = 0; c < 8; c++) begin
      #1;
      acks += int'(dmem_req_ack);
      if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
        oks++;
        rd0 = dmem_rdata;
      end
      if (c == 7) dmem_req = 1'b0;
      @(negedge clk);
    end
    repeat (3) begin
      if (dmem_resp != SCR1_MEM_RESP_NOTRDY) oks++;
      @(negedge clk);
    end
    chk("b2b acks",    160'(acks),          160'(2));
    chk("b2b rdy_ok",  160'(oks),           160'(2));
    chk("b2b sram_ce", 160'(ce_cnt - ce0),  160'(2));
    chk("b2b rdata",   rd0,                 {128'h0, 32'hA0A0_0000});

    // Reset during cycle 2 of a FOUR_WORD write
    dmem_cmd   = SCR1_MEM_CMD_WR;
    dmem_width = SCR1_MEM_Y_WIDTH_FOUR_WORD;
    dmem_addr  = BASE + 32'h200;
    dmem_wdata = {32'h0, 32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
    dmem_req   = 1'b1;
    ce0 = ce_cnt;
    @(posedge clk);
    #1 dmem_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst abort ack", 160'({dmem_req_ack, dmem_resp}), 160'({1'b1, SCR1_MEM_RESP_NOTRDY}));
    any_resp = 1'b0;
    lat = 0;
    repeat (5) begin
      @(negedge clk);
      if (dmem_resp != SCR1_MEM_RESP_NOTRDY) any_resp = 1'b1;
    end
    chk("rst abort no resp", 160'(any_resp),        160'(1'b0));
    chk("rst abort sram_ce", 160'(ce_cnt - ce0),    160'(2));
    chk("rst abort words",
        {32'h0, mem[12'h83], mem[12'h82], mem[12'h81], mem[12'h80]},
        {32'h0, 32'h5A00_0083, 32'h5A00_0082, 32'hB1B1_B1B1, 32'hB0B0_B0B0});
    run_txn("after reset", '{SCR1_MEM_CMD_RD, SCR1_MEM_Y_WIDTH_FOUR_WORD, BASE + 32'h200, '0,
            SCR1_MEM_RESP_RDY_OK, 6,
            {32'h0, 32'h5A00_0083, 32'h5A00_0082, 32'hB1B1_B1B1, 32'hB0B0_B0B0}, 4});

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
